// File: rtl/mem_access_unit_if.sv
// Memory bus between the load/store unit (master) and the memory (slave).
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: turns control-unit load/store requests into single
// word-aligned bus transactions, handles byte/halfword lanes, sign/zero
// extension, alignment/encoding checks and a bounded wait for bus_ready.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               store_data,
  output logic [31:0]               load_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  mem_access_unit_if.master         bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE, ST_ERR} state_t;

  // Last wait-counter value still allowed in REQ before giving up.
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [7:0]  r_wait;
  logic [31:0] r_load_data;
  logic        w_start;
  logic        w_access_ok;

  // Encoding check: loads allow B/H/W/BU/HU, stores only B/H/W.
  function automatic logic f_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
    end
    return ok;
  endfunction

  // Natural alignment check; the size lives in funct3[1:0].
  function automatic logic f_aligned(input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3[1:0])
      2'b01:   ok = (a[0] == 1'b0);
      2'b10:   ok = (a == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Store data replicated across lanes so memory picks it up via the strobes.
  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      3'b000:  w = {4{d[7:0]}};
      3'b001:  w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Byte-lane enables for a store.
  function automatic logic [3:0] f_wstrb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3)
      3'b000:  s = 4'b0001 << a;
      3'b001:  s = a[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Lane extraction plus sign or zero extension of a loaded word.
  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] v;
    sh = rd >> {a, 3'b000};
    case (f3)
      3'b000:  v = {{24{sh[7]}}, sh[7:0]};
      3'b001:  v = {{16{sh[15]}}, sh[15:0]};
      3'b100:  v = {24'h000000, sh[7:0]};
      3'b101:  v = {16'h0000, sh[15:0]};
      default: v = rd;
    endcase
    return v;
  endfunction

  assign w_start     = mem_read | mem_write;
  assign w_access_ok = f_legal(mem_write, funct3) & f_aligned(funct3, addr[1:0]);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a bad access never reaches the bus.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next = w_access_ok ? ST_REQ : ST_ERR;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.bus_ready) begin
          w_next = ST_DONE;
        end else if (r_wait == LP_WAIT_LAST) begin
          w_next = ST_ERR;
        end else begin
          w_next = ST_REQ;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the request in IDLE so the bus fields stay stable through REQ.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr   <= 32'h0000_0000;
      r_funct3 <= 3'b000;
      r_we     <= 1'b0;
      r_wdata  <= 32'h0000_0000;
      r_wstrb  <= 4'b0000;
    end else if ((r_state == ST_IDLE) && w_start) begin
      r_addr   <= addr;
      r_funct3 <= funct3;
      r_we     <= mem_write;
      r_wdata  <= mem_write ? f_wdata(funct3, store_data) : 32'h0000_0000;
      r_wstrb  <= mem_write ? f_wstrb(funct3, addr[1:0]) : 4'b0000;
    end
  end

  // Wait counter: zero whenever REQ is entered, counts not-ready cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait <= 8'd0;
    end else if (r_state != ST_REQ) begin
      r_wait <= 8'd0;
    end else if (!bus.bus_ready) begin
      r_wait <= r_wait + 8'd1;
    end
  end

  // Load result register; only a completed load updates it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_load_data <= 32'h0000_0000;
    end else if ((r_state == ST_REQ) && bus.bus_ready && !r_we) begin
      r_load_data <= f_load(r_funct3, r_addr[1:0], bus.bus_rdata);
    end
  end

  assign bus.bus_req   = (r_state == ST_REQ);
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = {r_addr[31:2], 2'b00};
  assign bus.bus_wdata = r_wdata;
  assign bus.bus_wstrb = r_wstrb;
  assign load_data     = r_load_data;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE) || (r_state == ST_ERR);
  assign err           = (r_state == ST_ERR);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one default-timeout instance for the
// main scenarios, one TIMEOUT=4 instance whose memory never answers.
module tb_mem_access_unit;
  logic        clk;
  logic        resetn;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data, load_data2;
  logic        busy, done, err;
  logic        busy2, done2, err2;
  int          n_cmp;
  int          n_bad;
  int          cnt;

  mem_access_unit_if bus1 ();
  mem_access_unit_if bus2 ();

  mem_access_unit u_dut (
    .clk(clk), .resetn(resetn), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .load_data(load_data), .busy(busy), .done(done), .err(err), .bus(bus1)
  );

  mem_access_unit #(.TIMEOUT(4)) u_dut_to (
    .clk(clk), .resetn(resetn), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .load_data(load_data2), .busy(busy2), .done(done2), .err(err2), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cnt = 0;
    resetn = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
    bus1.bus_rdata = 32'h0; bus1.bus_ready = 1'b0;
    bus2.bus_rdata = 32'h0; bus2.bus_ready = 1'b0;
    tick(); tick();
    // reset values
    check("rst_req",   32'(bus1.bus_req), 32'd0);
    check("rst_we",    32'(bus1.bus_we), 32'd0);
    check("rst_wstrb", 32'(bus1.bus_wstrb), 32'd0);
    check("rst_addr",  bus1.bus_addr, 32'h0);
    check("rst_wdata", bus1.bus_wdata, 32'h0);
    check("rst_load",  load_data, 32'h0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    resetn = 1'b1;

    // LB at 0x103, memory ready at once
    funct3 = 3'b000; addr = 32'h0000_0103; mem_read = 1'b1;
    bus1.bus_rdata = 32'h80FF_1234; bus1.bus_ready = 1'b1;
    tick();
    mem_read = 1'b0;
    check("lb_req",    32'(bus1.bus_req), 32'd1);
    check("lb_addr",   bus1.bus_addr, 32'h0000_0100);
    check("lb_wstrb",  32'(bus1.bus_wstrb), 32'd0);
    check("lb_done_early", 32'(done), 32'd0);
    tick();
    check("lb_done",   32'(done), 32'd1);
    check("lb_err",    32'(err), 32'd0);
    check("lb_load",   load_data, 32'hFFFF_FF80);
    mem_read = 1'b1;   // start during the done cycle must be dropped
    tick();
    mem_read = 1'b0;
    check("start_on_done_ignored", 32'(busy), 32'd0);

    // SH at 0x206 with read also high: the store wins
    funct3 = 3'b001; addr = 32'h0000_0206; store_data = 32'h0000_ABCD;
    mem_read = 1'b1; mem_write = 1'b1;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    check("sh_we",     32'(bus1.bus_we), 32'd1);
    check("sh_addr",   bus1.bus_addr, 32'h0000_0204);
    check("sh_wstrb",  32'(bus1.bus_wstrb), 32'h0000_000C);
    check("sh_wdata",  bus1.bus_wdata, 32'hABCD_ABCD);
    tick();
    check("sh_done",   32'(done), 32'd1);
    check("sh_err",    32'(err), 32'd0);
    check("sh_load_kept", load_data, 32'hFFFF_FF80);
    tick();

    // misaligned LW at 0x102
    funct3 = 3'b010; addr = 32'h0000_0102; mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    check("lw_mis_req",  32'(bus1.bus_req), 32'd0);
    check("lw_mis_done", 32'(done), 32'd1);
    check("lw_mis_err",  32'(err), 32'd1);
    check("lw_mis_load", load_data, 32'hFFFF_FF80);
    tick();
    check("lw_mis_idle", 32'(busy), 32'd0);

    // illegal store encoding (funct3=100)
    funct3 = 3'b100; addr = 32'h0000_0000; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    check("st_ill_req", 32'(bus1.bus_req), 32'd0);
    check("st_ill_err", 32'(err), 32'd1);
    tick();

    // LHU at 0x0, ready delayed five cycles
    funct3 = 3'b101; addr = 32'h0000_0000; mem_read = 1'b1;
    bus1.bus_rdata = 32'h0000_F00D; bus1.bus_ready = 1'b0;
    tick();
    mem_read = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus1.bus_req) cnt++;
      tick();
    end
    bus1.bus_ready = 1'b1;
    if (bus1.bus_req) cnt++;
    tick();
    check("lhu_req_cycles", 32'(cnt), 32'd6);
    check("lhu_done", 32'(done), 32'd1);
    check("lhu_err",  32'(err), 32'd0);
    check("lhu_load", load_data, 32'h0000_F00D);
    tick();

    // timeout on the TIMEOUT=4 instance, SW at 0x300
    repeat (8) tick();
    check("to_idle_before", 32'(busy2), 32'd0);
    funct3 = 3'b010; addr = 32'h0000_0300; store_data = 32'h1234_5678; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    check("to_wstrb", 32'(bus2.bus_wstrb), 32'h0000_000F);
    check("to_wdata", bus2.bus_wdata, 32'h1234_5678);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus2.bus_req) cnt++;
      mem_read = (i == 1);
      tick();
    end
    mem_read = 1'b0;
    check("to_req_cycles", 32'(cnt), 32'd4);
    check("to_req_drop",   32'(bus2.bus_req), 32'd0);
    check("to_done",       32'(done2), 32'd1);
    check("to_err",        32'(err2), 32'd1);
    tick();
    check("to_idle_after", 32'(busy2), 32'd0);
    tick();
    check("to_pulse_ignored", 32'(busy2), 32'd0);

    // reset in the middle of a REQ
    bus1.bus_ready = 1'b0;
    funct3 = 3'b010; addr = 32'h0000_0010; mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    check("mid_req", 32'(bus1.bus_req), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_req",  32'(bus1.bus_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_load", load_data, 32'h0);
    tick();
    resetn = 1'b1;
    check("mid_rst_nodone", 32'(done), 32'd0);
    tick();
    check("mid_rst_nodone2", 32'(done), 32'd0);

    // first access after reset: LBU at 0x101
    funct3 = 3'b100; addr = 32'h0000_0101; mem_read = 1'b1;
    bus1.bus_rdata = 32'h80FF_1234; bus1.bus_ready = 1'b1;
    tick();
    mem_read = 1'b0;
    check("lbu_req", 32'(bus1.bus_req), 32'd1);
    tick();
    check("lbu_done", 32'(done), 32'd1);
    check("lbu_load", load_data, 32'h0000_0012);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles spent waiting for mem_ready before abort (range 1..255).
REQ-002 clk  input  1  single system clock; all state SHALL update on the rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 mem_read  input  1  load request from the control unit's MEM_RD state.
REQ-005 mem_write  input  1  store request from the control unit's MEM_WR state.
REQ-006 funct3  input  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 addr  input  32  byte address (ALUOut).
REQ-008 store_data  input  32  rs2 value for stores.
REQ-009 bus_req  output  1  memory request valid.
REQ-010 bus_we  output  1  1 = write, 0 = read.
REQ-011 bus_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-012 bus_wdata  output  32  lane-replicated store data.
REQ-013 bus_wstrb  output  4  byte-lane enables; 0000 on reads.
REQ-014 bus_rdata  input  32  memory read word.
REQ-015 bus_ready  input  1  memory completes the access in the cycle it is sampled high with bus_req.
REQ-016 load_data  output  32  extended load result (MDR).
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err  output  1  valid with done: misaligned, illegal funct3, or timeout.

Function
REQ-020 The FSM SHALL have four states: IDLE, REQ, DONE, ERR.
REQ-021 IDLE: start = mem_read|mem_write; on start, capture addr, funct3, store_data and access type; mem_write SHALL win if both are high.
REQ-022 IDLE start with a legal, aligned access -> REQ; a misaligned or illegal access -> ERR, with no bus_req issued.
REQ-023 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00. Illegal: load funct3 011/110/111; store funct3 with bit 2 set or equal to 011.
REQ-024 REQ: bus_req=1, with bus_addr/bus_we/bus_wdata/bus_wstrb held stable until bus_ready; on bus_ready -> DONE.
REQ-025 REQ SHALL include an 8-bit wait counter, cleared on entry and incremented each cycle bus_ready is low; reaching TIMEOUT -> ERR, with bus_req deasserted the following cycle.
REQ-026 Load completion: on the bus_ready cycle, load_data SHALL load the lane selected by captured addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
REQ-027 Stores: SB wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0]; SH wdata={2{d[15:0]}}, wstrb=0011 (addr[1]=0) or 1100; SW wdata=d, wstrb=1111.
REQ-028 DONE: done=1, err=0 for one cycle, then -> IDLE.
REQ-029 ERR: done=1, err=1 for one cycle, then -> IDLE; load_data SHALL be unchanged.
REQ-030 Latency with zero memory wait states: done SHALL be asserted 2 cycles after the edge that samples start.
REQ-031 start SHALL be ignored while busy=1; a start in the same cycle as done SHALL be ignored, and the next start is accepted in IDLE.
REQ-032 load_data SHALL hold its value until the next successful load; stores and errors SHALL NOT modify it.
REQ-033 Outputs SHALL be registered or decoded only from state and captured registers, with no combinational path from mem_read/mem_write to bus_req.

Reset
REQ-034 resetn low SHALL immediately force IDLE, with bus_req=0, bus_we=0, bus_wstrb=0000, bus_addr=0, bus_wdata=0, load_data=0, busy=0, done=0, err=0, and wait counter=0.
REQ-035 Reset asserted during REQ SHALL abort the access with no done pulse; the first start after resetn rises SHALL behave normally.

Verification
REQ-036 LB, addr=0x103, bus_rdata=0x80FF_1234, bus_ready high immediately -> bus_addr=0x100, load_data=0xFFFFFF80, done 2 cycles after start, err=0.
REQ-037 SH, addr=0x206, store_data=0x0000_ABCD -> bus_we=1, bus_wstrb=1100, bus_wdata=0xABCD_ABCD, done=1, err=0.
REQ-038 LW, addr=0x102 -> no bus_req, done=1 and err=1 one cycle after start, load_data unchanged.
REQ-039 LHU, addr=0x0, bus_ready delayed 5 cycles, bus_rdata=0x0000_F00D -> bus_req high for 6 cycles, load_data=0x0000F00D.
REQ-040 TIMEOUT=4, SW, bus_ready held low -> after 4 wait cycles the FSM enters ERR, done=1, err=1, and bus_req drops; mem_read pulsed during busy is ignored.
REQ-041 resetn pulsed low mid-REQ -> bus_req=0 and busy=0 asynchronously, with no done pulse.
